// File: rtl/receivers_pkg.sv
// Shared definitions for the triad receiver family: channel limits and the FIFO entry layout.
// An entry is {data, reset_pulse_id, triad_id}; the tag sits at the bottom so its layout does not depend on TRIAD_DATA_W.
package receivers_pkg;

  localparam int MAX_TRIADS       = 8;
  localparam int DEF_TRIAD_DATA_W = 68;
  localparam int ID_W             = 3;
  localparam int TAG_W            = ID_W + 1;
  localparam int ENTRY_ID_LSB     = 0;
  localparam int ENTRY_RPID_BIT   = ID_W;
  localparam int ENTRY_DATA_LSB   = TAG_W;

  function automatic logic [TAG_W-1:0] pack_tag(input logic [ID_W-1:0] id, input logic rpid);
    logic [TAG_W-1:0] tag;
    tag = {TAG_W{1'b0}};
    tag[ENTRY_ID_LSB +: ID_W] = id;
    tag[ENTRY_RPID_BIT] = rpid;
    return tag;
  endfunction

  function automatic logic [ID_W-1:0] tag_id(input logic [TAG_W-1:0] tag);
    return tag[ENTRY_ID_LSB +: ID_W];
  endfunction

  function automatic logic tag_rpid(input logic [TAG_W-1:0] tag);
    return tag[ENTRY_RPID_BIT];
  endfunction

endpackage

// File: rtl/multi_triad_aggregator_sync_fifo.sv
// Show-ahead synchronous FIFO; push and pop may coincide at any level, including full.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      level_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify requests: pops on empty are ignored, pushes on full need a concurrent pop.
  always_comb begin
    do_pop_s  = pop && (level_r != (AW+1)'(0));
    do_push_s = push && ((level_r != (AW+1)'(DEPTH)) || do_pop_s);
  end

  // Storage array, cleared on reset so the head reads 0 afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Pointers and exact occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   level_r <= level_r + (AW+1)'(1);
        2'b01:   level_r <= level_r - (AW+1)'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  assign rd_data = mem_r[rd_ptr_r];
  assign full    = (level_r == (AW+1)'(DEPTH));
  assign empty   = (level_r == (AW+1)'(0));
  assign level   = level_r;

endmodule

// File: rtl/multi_triad_aggregator.sv
// Collects results from NUM_TRIADS triad managers, arbitrates them round-robin into one FIFO
// and owns the shared sys_ts timestamp counter.
module multi_triad_aggregator
  import receivers_pkg::*;
#(
  parameter int NUM_TRIADS   = 4,
  parameter int TRIAD_DATA_W = DEF_TRIAD_DATA_W,
  parameter int FIFO_DEPTH   = 8,
  parameter int TS_W         = 24,
  parameter int DROP_CNT_W   = 8
) (
  input  logic                               clk_96MHz,
  input  logic                               reset,
  output logic [TS_W-1:0]                    sys_ts,
  input  logic [NUM_TRIADS-1:0]              triad_data_avl,
  input  logic [NUM_TRIADS*TRIAD_DATA_W-1:0] triad_data,
  input  logic [NUM_TRIADS-1:0]              triad_reset_pulse_id,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [TRIAD_DATA_W-1:0]            out_data,
  output logic [2:0]                         out_triad_id,
  output logic                               out_reset_pulse_id,
  output logic [$clog2(FIFO_DEPTH):0]        fifo_level,
  output logic [NUM_TRIADS*DROP_CNT_W-1:0]   drop_cnt
);

  localparam int ENTRY_W = TRIAD_DATA_W + TAG_W;

  logic [TS_W-1:0]         sys_ts_r;
  logic [NUM_TRIADS-1:0]   pending_r;
  logic [TRIAD_DATA_W-1:0] hold_data_r [NUM_TRIADS];
  logic [NUM_TRIADS-1:0]   hold_rpid_r;
  logic [DROP_CNT_W-1:0]   drop_cnt_r [NUM_TRIADS];
  logic [ID_W-1:0]         ptr_r;

  logic                    grant_vld_s;
  logic [ID_W-1:0]         grant_idx_s;
  logic [ENTRY_W-1:0]      grant_entry_s;
  logic                    pop_s;
  logic                    can_grant_s;
  logic                    fifo_full_s;
  logic                    fifo_empty_s;
  logic [ENTRY_W-1:0]      head_s;

  assign pop_s       = !fifo_empty_s && out_ready;
  assign can_grant_s = !fifo_full_s || pop_s;

  // Round-robin pick: lowest pending index at or above ptr, else lowest pending overall.
  always_comb begin
    grant_vld_s   = 1'b0;
    grant_idx_s   = {ID_W{1'b0}};
    grant_entry_s = {ENTRY_W{1'b0}};
    for (int i = 0; i < NUM_TRIADS; i++) begin
      if (can_grant_s && !grant_vld_s && pending_r[i] && (i >= int'(ptr_r))) begin
        grant_vld_s   = 1'b1;
        grant_idx_s   = ID_W'(i);
        grant_entry_s = {hold_data_r[i], pack_tag(ID_W'(i), hold_rpid_r[i])};
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
    for (int i = 0; i < NUM_TRIADS; i++) begin
      if (can_grant_s && !grant_vld_s && pending_r[i]) begin
        grant_vld_s   = 1'b1;
        grant_idx_s   = ID_W'(i);
        grant_entry_s = {hold_data_r[i], pack_tag(ID_W'(i), hold_rpid_r[i])};
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  // Timestamp, arbiter pointer and per-channel capture with newest-wins overwrite.
  always_ff @(posedge clk_96MHz) begin
    if (reset) begin
      sys_ts_r    <= {TS_W{1'b0}};
      ptr_r       <= {ID_W{1'b0}};
      pending_r   <= {NUM_TRIADS{1'b0}};
      hold_rpid_r <= {NUM_TRIADS{1'b0}};
      for (int i = 0; i < NUM_TRIADS; i++) begin
        hold_data_r[i] <= {TRIAD_DATA_W{1'b0}};
        drop_cnt_r[i]  <= {DROP_CNT_W{1'b0}};
      end
    end else begin
      sys_ts_r <= sys_ts_r + TS_W'(1);
      if (grant_vld_s) begin
        ptr_r <= (grant_idx_s == ID_W'(NUM_TRIADS-1)) ? {ID_W{1'b0}} : grant_idx_s + ID_W'(1);
      end
      for (int i = 0; i < NUM_TRIADS; i++) begin
        if (triad_data_avl[i]) begin
          hold_data_r[i] <= triad_data[i*TRIAD_DATA_W +: TRIAD_DATA_W];
          hold_rpid_r[i] <= triad_reset_pulse_id[i];
          pending_r[i]   <= 1'b1;
          // A recapture only loses data when the old entry was not moved to the FIFO this edge.
          if (pending_r[i] && !(grant_vld_s && (grant_idx_s == ID_W'(i)))
              && (drop_cnt_r[i] != {DROP_CNT_W{1'b1}})) begin
            drop_cnt_r[i] <= drop_cnt_r[i] + DROP_CNT_W'(1);
          end
        end else if (grant_vld_s && (grant_idx_s == ID_W'(i))) begin
          pending_r[i] <= 1'b0;
        end
      end
    end
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk_96MHz),
    .reset   (reset),
    .push    (grant_vld_s),
    .wr_data (grant_entry_s),
    .pop     (pop_s),
    .rd_data (head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .level   (fifo_level)
  );

  // Flatten the per-channel drop counters onto the output bus.
  always_comb begin
    drop_cnt = {(NUM_TRIADS*DROP_CNT_W){1'b0}};
    for (int i = 0; i < NUM_TRIADS; i++) begin
      drop_cnt[i*DROP_CNT_W +: DROP_CNT_W] = drop_cnt_r[i];
    end
  end

  assign sys_ts             = sys_ts_r;
  assign out_valid          = !fifo_empty_s;
  assign out_data           = head_s[ENTRY_DATA_LSB +: TRIAD_DATA_W];
  assign out_triad_id       = tag_id(head_s[TAG_W-1:0]);
  assign out_reset_pulse_id = tag_rpid(head_s[TAG_W-1:0]);

endmodule

// File: tb/tb_multi_triad_aggregator.sv
// Directed bench for multi_triad_aggregator with a queue scoreboard of expected output beats.
module tb_multi_triad_aggregator;

  logic clk_96MHz = 1'b0;
  always #5 clk_96MHz = ~clk_96MHz;

  logic          reset;
  logic [3:0]    avl;
  logic [271:0]  tdata;
  logic [3:0]    rpid;
  logic          out_ready;
  logic [23:0]   sys_ts;
  logic          out_valid;
  logic [67:0]   out_data;
  logic [2:0]    out_triad_id;
  logic          out_reset_pulse_id;
  logic [3:0]    fifo_level;
  logic [31:0]   drop_cnt;

  // second instance with a narrow timestamp for the wrap check
  logic [3:0]    z_avl = 4'd0;
  logic [271:0]  z_data = 272'd0;
  logic [3:0]    z_rpid = 4'd0;
  logic          z_ready = 1'b0;
  logic [3:0]    ts4;
  logic          s_valid;
  logic [67:0]   s_data;
  logic [2:0]    s_id;
  logic          s_rpid;
  logic [3:0]    s_level;
  logic [31:0]   s_drop;

  multi_triad_aggregator dut (
    .clk_96MHz(clk_96MHz), .reset(reset), .sys_ts(sys_ts),
    .triad_data_avl(avl), .triad_data(tdata), .triad_reset_pulse_id(rpid),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_triad_id(out_triad_id), .out_reset_pulse_id(out_reset_pulse_id),
    .fifo_level(fifo_level), .drop_cnt(drop_cnt)
  );

  multi_triad_aggregator #(.TS_W(4)) dut_ts4 (
    .clk_96MHz(clk_96MHz), .reset(reset), .sys_ts(ts4),
    .triad_data_avl(z_avl), .triad_data(z_data), .triad_reset_pulse_id(z_rpid),
    .out_valid(s_valid), .out_ready(z_ready), .out_data(s_data),
    .out_triad_id(s_id), .out_reset_pulse_id(s_rpid),
    .fifo_level(s_level), .drop_cnt(s_drop)
  );

  int total = 0;
  int bad   = 0;
  int beats = 0;
  logic [71:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [67:0] mk(input int ch, input int n);
    return {4'hA, 32'(n), 32'(ch)};
  endfunction

  task automatic drive(input int ch, input int n);
    tdata[ch*68 +: 68] = mk(ch, n);
    rpid[ch] = 1'(ch % 2);
    avl[ch]  = 1'b1;
  endtask

  task automatic exp_push(input int ch, input int n);
    exp_q.push_back({3'(ch), 1'(ch % 2), mk(ch, n)});
  endtask

  // Score the beat accepted at the coming edge, then advance one cycle to the next negedge.
  task automatic tick();
    logic [71:0] e;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 128'(exp_q.size()), 128'(1));
      end else begin
        e = exp_q.pop_front();
        check("beat_id",   128'(out_triad_id),       128'(e[71:69]));
        check("beat_rpid", 128'(out_reset_pulse_id), 128'(e[68]));
        check("beat_data", 128'(out_data),           128'(e[67:0]));
        beats++;
      end
    end
    @(posedge clk_96MHz);
    @(negedge clk_96MHz);
  endtask

  task automatic drain(input int max_cycles);
    out_ready = 1'b1;
    for (int k = 0; k < max_cycles && (out_valid || exp_q.size() != 0); k++) tick();
    check("drain_valid_low", 128'(out_valid), 128'(0));
    check("drain_sb_empty",  128'(exp_q.size()), 128'(0));
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; avl = 4'd0; tdata = 272'd0; rpid = 4'd0; out_ready = 1'b0;
    tick(); tick();
    check("rst_sys_ts",   128'(sys_ts),             128'(0));
    check("rst_valid",    128'(out_valid),          128'(0));
    check("rst_level",    128'(fifo_level),         128'(0));
    check("rst_data",     128'(out_data),           128'(0));
    check("rst_id",       128'(out_triad_id),       128'(0));
    check("rst_rpid",     128'(out_reset_pulse_id), 128'(0));
    check("rst_drop",     128'(drop_cnt),           128'(0));
    reset = 1'b0;

    // idle 20 cycles
    repeat (20) tick();
    check("idle_sys_ts",  128'(sys_ts),     128'(20));
    check("idle_valid",   128'(out_valid),  128'(0));
    check("idle_level",   128'(fifo_level), 128'(0));
    check("idle_drop",    128'(drop_cnt),   128'(0));
    check("ts4_idle",     128'(ts4),        128'(4));

    // narrow timestamp wraps 15 -> 0
    repeat (11) tick();
    check("ts4_at_15",    128'(ts4),    128'(15));
    check("ts_at_31",     128'(sys_ts), 128'(31));
    tick();
    check("ts4_wrap_0",   128'(ts4),    128'(0));
    check("ts_at_32",     128'(sys_ts), 128'(32));

    // single pulse on channel 2, ready high
    out_ready = 1'b1; beats = 0;
    tdata[2*68 +: 68] = 68'h1_2345_6789_ABCD_EF01;
    rpid = 4'b0100; avl = 4'b0100;
    exp_q.push_back({3'd2, 1'b1, 68'h1_2345_6789_ABCD_EF01});
    tick();
    avl = 4'd0;
    check("lat_after_pulse", 128'(out_valid), 128'(0));
    tick();
    check("lat_two_cycles",  128'(out_valid),    128'(1));
    check("single_id",       128'(out_triad_id), 128'(2));
    check("single_data",     128'(out_data),     128'(68'h1_2345_6789_ABCD_EF01));
    tick();
    check("single_one_beat", 128'(out_valid), 128'(0));
    check("single_beats",    128'(beats),     128'(1));

    // simultaneous pulses from ptr=0: order 0,1,2,3
    do_reset();
    out_ready = 1'b0; beats = 0;
    for (int ch = 0; ch < 4; ch++) begin drive(ch, 1); exp_push(ch, 1); end
    tick();
    avl = 4'd0;
    check("rr0_level_0", 128'(fifo_level), 128'(0));
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("rr0_level", 128'(fifo_level), 128'(k));
    end
    tick();
    check("rr0_level_hold", 128'(fifo_level), 128'(4));
    drain(20);
    check("rr0_beats", 128'(beats), 128'(4));

    // channel 1 alone moves ptr to 2, then all four: order 2,3,0,1
    drive(1, 2); exp_push(1, 2);
    tick();
    avl = 4'd0;
    drain(20);
    beats = 0;
    for (int ch = 0; ch < 4; ch++) drive(ch, 3);
    exp_push(2, 3); exp_push(3, 3); exp_push(0, 3); exp_push(1, 3);
    tick();
    avl = 4'd0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("rr2_level", 128'(fifo_level), 128'(k));
    end
    drain(20);
    check("rr2_beats", 128'(beats), 128'(4));

    // overflow: 10 back-to-back pulses on channel 1 with ready low
    do_reset();
    out_ready = 1'b0; beats = 0;
    for (int n = 1; n <= 10; n++) begin
      drive(1, n);
      if (n != 9) exp_push(1, n);
      tick();
    end
    avl = 4'd0;
    check("ovf_level",     128'(fifo_level),     128'(8));
    check("ovf_drop1",     128'(drop_cnt[15:8]), 128'(1));
    check("ovf_drop0",     128'(drop_cnt[7:0]),  128'(0));
    check("ovf_drop23",    128'(drop_cnt[31:16]),128'(0));
    check("ovf_valid",     128'(out_valid),      128'(1));
    repeat (3) tick();
    check("ovf_level_hold",128'(fifo_level),     128'(8));
    drain(30);
    check("ovf_beats",     128'(beats),          128'(9));
    check("ovf_drop_keep", 128'(drop_cnt[15:8]), 128'(1));

    // full FIFO streaming with a pulse every cycle, then reset mid-stream
    do_reset();
    out_ready = 1'b0;
    for (int n = 1; n <= 9; n++) begin drive(0, n); exp_push(0, n); tick(); end
    check("stream_full", 128'(fifo_level), 128'(8));
    out_ready = 1'b1; beats = 0;
    for (int n = 10; n <= 19; n++) begin
      drive(0, n); exp_push(0, n);
      tick();
      check("stream_level", 128'(fifo_level), 128'(8));
      check("stream_valid", 128'(out_valid),  128'(1));
    end
    check("stream_beats", 128'(beats),    128'(10));
    check("stream_drop",  128'(drop_cnt), 128'(0));
    reset = 1'b1;
    tick();
    check("midrst_valid", 128'(out_valid),  128'(0));
    check("midrst_level", 128'(fifo_level), 128'(0));
    check("midrst_ts",    128'(sys_ts),     128'(0));
    exp_q.delete();
    reset = 1'b0; avl = 4'd0;
    tick(); tick();
    check("postrst_valid", 128'(out_valid),  128'(0));
    check("postrst_level", 128'(fifo_level), 128'(0));
    check("postrst_drop",  128'(drop_cnt),   128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
